// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin byte-serial arbiter from N_CH requesters onto the 8-bit memory bus
module mem_arbiter #(
  parameter int              N_CH       = 2,
  parameter int              MAX_BYTES  = 4,
  parameter logic [N_CH-1:0] FLUSH_MASK = {N_CH{1'b1}}
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        clr_in,
  input  logic                        io_buffer_full,
  input  logic [7:0]                  mem_din,
  output logic [7:0]                  mem_dout,
  output logic [31:0]                 mem_a,
  output logic                        mem_wr,
  input  logic [N_CH-1:0]             req_valid,
  input  logic [N_CH-1:0]             req_we,
  input  logic [N_CH*4-1:0]           req_len,
  input  logic [N_CH*32-1:0]          req_addr,
  input  logic [N_CH*8*MAX_BYTES-1:0] req_wdata,
  output logic [N_CH-1:0]             done,
  output logic [8*MAX_BYTES-1:0]      rdata
);

  localparam int         CW      = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int         DW      = 8 * MAX_BYTES;
  localparam logic [3:0] LEN_MAX = 4'(MAX_BYTES - 1);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t          state;
  logic [CW-1:0]   ptr;
  logic [CW-1:0]   cur;
  logic [31:0]     addr_q;
  logic [3:0]      len_q;
  logic [3:0]      idx;
  logic [3:0]      pend_idx;
  logic            pend;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;
  logic [N_CH-1:0] done_q;
  logic            done_we;

  logic [N_CH-1:0] eligible;
  logic            grant_ok;
  logic [CW-1:0]   grant;
  logic [CW-1:0]   ptr_next;
  logic            sel_we;
  logic [3:0]      sel_len;
  logic [31:0]     sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [7:0]      wbyte;
  logic            stall;

  // Scan downward so the lowest offset from ptr is the last (winning) assignment.
  always_comb begin
    int j;
    j        = 0;
    eligible = req_valid & ~(clr_in ? FLUSH_MASK : '0);
    grant_ok = 1'b0;
    grant    = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N_CH) j = j - N_CH;
      if (eligible[CW'(j)]) begin
        grant_ok = 1'b1;
        grant    = CW'(j);
      end
    end
  end

  assign ptr_next = (grant == CW'(N_CH - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    sel_we    = 1'b0;
    sel_len   = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (grant == CW'(c)) begin
        sel_we    = req_we[c];
        sel_len   = req_len[c*4 +: 4];
        sel_addr  = req_addr[c*32 +: 32];
        sel_wdata = req_wdata[c*DW +: DW];
      end
    end
  end

  assign stall = (addr_q[17:16] == 2'b11) && io_buffer_full;

  always_comb begin
    wbyte = '0;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (idx == 4'(b)) wbyte = wdata_q[b*8 +: 8];
    end
  end

  always_comb begin
    mem_a    = '0;
    mem_dout = '0;
    mem_wr   = 1'b0;
    if (state == WR) begin
      mem_a    = addr_q + {28'd0, idx};
      mem_dout = wbyte;
      mem_wr   = rdy_in && !stall;
    end else if (state == RD && idx <= len_q) begin
      mem_a = addr_q + {28'd0, idx};
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state    <= IDLE;
      ptr      <= '0;
      cur      <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      idx      <= '0;
      pend_idx <= '0;
      pend     <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      done_q   <= '0;
      done_we  <= 1'b0;
    end else if (!rdy_in) begin
      // A return byte due in a paused cycle is lost; rewind so it is fetched again.
      if (state == RD && pend) begin
        idx  <= pend_idx;
        pend <= 1'b0;
      end
    end else begin
      done_q <= '0;
      case (state)
        IDLE: begin
          if (done_q == '0 && grant_ok) begin
            cur     <= grant;
            ptr     <= ptr_next;
            addr_q  <= sel_addr;
            len_q   <= (sel_len > LEN_MAX) ? LEN_MAX : sel_len;
            wdata_q <= sel_wdata;
            rdata_q <= '0;
            idx     <= '0;
            pend    <= 1'b0;
            done_we <= sel_we;
            state   <= sel_we ? WR : RD;
          end
        end
        RD: begin
          if (clr_in && FLUSH_MASK[cur]) begin
            pend  <= 1'b0;
            state <= IDLE;
          end else begin
            if (pend) begin
              for (int b = 0; b < MAX_BYTES; b++) begin
                if (pend_idx == 4'(b)) rdata_q[b*8 +: 8] <= mem_din;
              end
            end
            if (idx <= len_q) begin
              pend     <= 1'b1;
              pend_idx <= idx;
              idx      <= idx + 4'd1;
            end else begin
              pend <= 1'b0;
            end
            if (pend && pend_idx == len_q) begin
              done_q <= N_CH'(1) << cur;
              state  <= IDLE;
            end
          end
        end
        WR: begin
          if (!stall) begin
            if (idx == len_q) begin
              done_q <= N_CH'(1) << cur;
              state  <= IDLE;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A flush landing on the completion cycle still cancels a masked read's done.
  assign done  = done_q & ~((clr_in && rdy_in && !done_we) ? FLUSH_MASK : '0);
  assign rdata = rdata_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised byte-serial memory arbiter between N_CH requesters (instruction fetch, load/store buffer, future prefetch/DMA) and the single 8-bit RAM/IO bus of the RISC-V core. It serialises each 1..MAX_BYTES-byte request onto the bus, returns assembled little-endian read data, and grants channels round-robin. It supports selective flush, an IO-write back-pressure stall, and a global pause.

## Interface
Parameters:
- N_CH, 2: number of requester channels (2..8).
- MAX_BYTES, 4: maximum bytes per transaction (power of 2, 1..8).
- FLUSH_MASK, 2'b11: bit c = 1 means channel c reads are abortable by clr_in (width N_CH).

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  asynchronous, active-low reset.
- rdy_in  in  1  pause when low.
- clr_in  in  1  misprediction flush, one-cycle pulse.
- io_buffer_full  in  1  UART TX buffer full.
- mem_din  in  8  read data byte; valid the cycle after its address.
- mem_dout  out  8  write data byte.
- mem_a  out  32  byte address.
- mem_wr  out  1  1 = write.
- req_valid  in  N_CH  per-channel request; held until done.
- req_we  in  N_CH  1 = write.
- req_len  in  N_CH*4  byte count minus 1 per channel.
- req_addr  in  N_CH*32  start address per channel.
- req_wdata  in  N_CH*8*MAX_BYTES  write data, byte 0 in LSBs.
- done  out  N_CH  one-cycle completion pulse per channel.
- rdata  out  8*MAX_BYTES  read result, zero-extended above len; valid with done.

## Operation
- States: IDLE, RD, WR. Reset: IDLE, rr pointer 0, all outputs 0.
- IDLE: pick the first requesting channel scanning from pointer upward, mod N_CH. Latch addr/len/wdata/we. Set pointer = granted+1 mod N_CH. Enter RD or WR.
- RD: present mem_a = addr+i for i = 0..len, mem_wr=0. Capture mem_din one cycle later into byte i of rdata. After the last byte is captured, pulse done[c] and return to IDLE.
- WR: present mem_a = addr+i, mem_dout = wdata byte i, mem_wr=1 for i = 0..len. Pulse done[c] the cycle after the last byte and return to IDLE.
- IO stall: in WR, if addr[17:16]==2'b11 and io_buffer_full=1, drive mem_wr=0 and hold byte i. Resume when io_buffer_full falls.
- Idle bus: mem_a=0, mem_dout=0, mem_wr=0.
- req_len > MAX_BYTES-1 is clamped to MAX_BYTES-1.
- Address arithmetic is 32-bit wrap.

## Timing
- Grant in cycle t (IDLE sees req_valid).
- Read: bytes on bus t+1..t+1+len; done at t+3+len. A 4-byte read completes in 6 cycles.
- Write: bytes on bus t+1..t+1+len; done at t+2+len.
- Re-arbitration happens in the cycle after done; the granted channel must have deasserted req_valid by then. Minimum gap between transactions is 1 idle cycle.
- rdy_in=0: all state, counters and outputs freeze, except mem_wr, which is forced 0. Nothing is sampled that cycle. A read byte whose return cycle falls in a pause is re-issued after resume.
- clr_in=1 during RD for a channel in FLUSH_MASK: abort, no done, IDLE next cycle.
- clr_in=1 in IDLE: requests from masked channels are not granted that cycle.
- Writes are never aborted.
- clr_in together with the done cycle: done is suppressed for masked channels.
- Reset mid-transaction: immediate IDLE, mem_wr=0 asynchronously; partial data is discarded.

## Test plan
- Single read, ch0, addr 0x100, len 3, mem bytes 11 22 33 44 -> rdata=0x44332211, done[0] 5 cycles after grant cycle +1 (6 total).
- ch0 and ch1 both request continuously, pointer 0 -> grants alternate ch0, ch1, ch0. No channel is granted twice in a row while the other waits.
- Write to 0x30000 len 0 data 0x41 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for 3 cycles, then 1 cycle of mem_wr=1 with mem_dout=0x41, then done.
- clr_in pulse during the 2nd byte of a ch0 4-byte read (FLUSH_MASK=2'b11) -> no done[0], IDLE next cycle. A pending ch1 write still completes.
- rdy_in low for 2 cycles mid 2-byte write -> mem_wr=0 during the pause, same byte re-presented after resume. Total latency grows by exactly 2.
- Assert rst_in low mid-read -> mem_wr, done, mem_a are 0 in the same cycle. After release, the first request completes normally.
